branch_redirect: RTL and testbench

//  EX-stage consumer of branch_taken from the branch comparator. Decides control-flow changes for

---
 rtl/branch_redirect_pkg.sv | 21 ++
 rtl/branch_redirect_if.sv | 41 ++++
 rtl/branch_target_calc.sv | 29 ++
 rtl/branch_redirect.sv | 115 +++++++++++
 tb/tb_branch_redirect.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/branch_redirect_pkg.sv
// Shared types and constants for the EX-stage branch redirect block.
// Provides the redirect FSM state encoding and the conditional-branch funct3 codes.
package branch_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // funct3 encodings of the conditional branches resolved by the comparator upstream
  localparam logic [2:0] BEQ  = 3'b000;
  localparam logic [2:0] BNE  = 3'b001;
  localparam logic [2:0] BLT  = 3'b100;
  localparam logic [2:0] BGE  = 3'b101;
  localparam logic [2:0] BLTU = 3'b110;
  localparam logic [2:0] BGEU = 3'b111;

endpackage

// File: rtl/branch_redirect_if.sv
// EX-side instruction handshake, fetch redirect request and status outputs of branch_redirect.
// master = EX stage / fetch side, slave = branch_redirect.
interface branch_redirect_if #(
  parameter int XLEN  = branch_pkg::XLEN_DEFAULT,
  parameter int CNT_W = 32
);
  logic            ex_valid;
  logic            ex_ready;
  logic            ex_is_branch;
  logic            ex_is_jal;
  logic            ex_is_jalr;
  logic            branch_taken;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_imm;
  logic [XLEN-1:0] ex_rs1;

  logic            redir_valid;
  logic            redir_ready;
  logic [XLEN-1:0] redir_pc;

  logic            flush;
  logic            exc_misaligned;
  logic [XLEN-1:0] exc_pc;

  logic [CNT_W-1:0] stat_branches;
  logic [CNT_W-1:0] stat_taken;

  modport master (
    output ex_valid, ex_is_branch, ex_is_jal, ex_is_jalr, branch_taken,
    output ex_pc, ex_imm, ex_rs1, redir_ready,
    input  ex_ready, redir_valid, redir_pc, flush, exc_misaligned, exc_pc,
    input  stat_branches, stat_taken
  );

  modport slave (
    input  ex_valid, ex_is_branch, ex_is_jal, ex_is_jalr, branch_taken,
    input  ex_pc, ex_imm, ex_rs1, redir_ready,
    output ex_ready, redir_valid, redir_pc, flush, exc_misaligned, exc_pc,
    output stat_branches, stat_taken
  );
endinterface

// File: rtl/branch_target_calc.sv
// Combinational control-flow decision: take flag, target address and misalignment.
// JALR targets have bit 0 cleared; all sums wrap modulo 2^XLEN.
module branch_target_calc #(
  parameter int XLEN = branch_pkg::XLEN_DEFAULT
) (
  input  logic            is_branch,
  input  logic            is_jal,
  input  logic            is_jalr,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1,
  output logic            take,
  output logic [XLEN-1:0] target,
  output logic            misaligned
);

  logic [XLEN-1:0] base;
  logic [XLEN-1:0] sum;

  assign base   = is_jalr ? rs1 : pc;
  assign sum    = base + imm;
  assign target = is_jalr ? {sum[XLEN-1:1], 1'b0} : sum;

  assign take       = is_jal | is_jalr | (is_branch & branch_taken);
  // Only 4-byte alignment is legal: bit 1 set means a half-word target
  assign misaligned = take & target[1];

endmodule

// File: rtl/branch_redirect.sv
// EX-stage redirect controller: accepts a resolved control-flow instruction, requests a fetch
// redirect, flushes the front end and reports misaligned targets. Optional macro BRANCH_STATS_EN.
module branch_redirect
  import branch_pkg::*;
#(
  parameter int XLEN         = XLEN_DEFAULT,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  branch_redirect_if.slave bus
);

  localparam int CW = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;

  state_e          state;
  logic [CW-1:0]   flush_cnt;
  logic            take;
  logic            misaligned;
  logic [XLEN-1:0] target;
  logic            accept;

  branch_target_calc #(.XLEN(XLEN)) u_target (
    .is_branch    (bus.ex_is_branch),
    .is_jal       (bus.ex_is_jal),
    .is_jalr      (bus.ex_is_jalr),
    .branch_taken (bus.branch_taken),
    .pc           (bus.ex_pc),
    .imm          (bus.ex_imm),
    .rs1          (bus.ex_rs1),
    .take         (take),
    .target       (target),
    .misaligned   (misaligned)
  );

  assign bus.ex_ready = (state == IDLE);
  assign accept       = bus.ex_valid & bus.ex_ready;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state              <= IDLE;
      flush_cnt          <= '0;
      bus.redir_valid    <= 1'b0;
      bus.redir_pc       <= '0;
      bus.flush          <= 1'b0;
      bus.exc_misaligned <= 1'b0;
      bus.exc_pc         <= '0;
    end else begin
      bus.exc_misaligned <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept && take && !misaligned) begin
            state           <= REQ;
            bus.redir_valid <= 1'b1;
            bus.redir_pc    <= target;
            bus.flush       <= 1'b1;
          end else if (accept && misaligned) begin
            bus.exc_misaligned <= 1'b1;
            bus.exc_pc         <= bus.ex_pc;
          end
        end
        REQ: begin
          // redir_valid/redir_pc hold until fetch takes the request
          if (bus.redir_ready) begin
            bus.redir_valid <= 1'b0;
            if (FLUSH_CYCLES == 0) begin
              state     <= IDLE;
              bus.flush <= 1'b0;
            end else begin
              state     <= DRAIN;
              flush_cnt <= CW'(FLUSH_CYCLES);
            end
          end
        end
        DRAIN: begin
          flush_cnt <= flush_cnt - CW'(1);
          if (flush_cnt == CW'(1)) begin
            state     <= IDLE;
            bus.flush <= 1'b0;
          end
        end
        default: begin
          state           <= IDLE;
          bus.redir_valid <= 1'b0;
          bus.flush       <= 1'b0;
        end
      endcase
    end
  end

`ifdef BRANCH_STATS_EN
  logic [CNT_W-1:0] stat_branches_q;
  logic [CNT_W-1:0] stat_taken_q;

  // Saturating counters: they stick at all-ones rather than wrapping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_branches_q <= '0;
      stat_taken_q    <= '0;
    end else if (accept && bus.ex_is_branch) begin
      if (stat_branches_q != '1) stat_branches_q <= stat_branches_q + CNT_W'(1);
      if (bus.branch_taken && (stat_taken_q != '1)) stat_taken_q <= stat_taken_q + CNT_W'(1);
    end
  end

  assign bus.stat_branches = stat_branches_q;
  assign bus.stat_taken    = stat_taken_q;
`else
  assign bus.stat_branches = '0;
  assign bus.stat_taken    = '0;
`endif

endmodule

// File: tb/tb_branch_redirect.sv
// Directed self-checking bench for branch_redirect (FLUSH_CYCLES=2).
// Stimulus is applied 1 time unit after the rising edge; outputs are sampled at the same point.
module tb_branch_redirect;

  localparam int XLEN  = 32;
  localparam int CNT_W = 32;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  branch_redirect_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

  branch_redirect #(.XLEN(XLEN), .FLUSH_CYCLES(2), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bus.ex_valid     = 1'b0;
    bus.ex_is_branch = 1'b0;
    bus.ex_is_jal    = 1'b0;
    bus.ex_is_jalr   = 1'b0;
    bus.branch_taken = 1'b0;
    bus.ex_pc        = '0;
    bus.ex_imm       = '0;
    bus.ex_rs1       = '0;
  endtask

  // Present one instruction for exactly one clock edge.
  task automatic issue(input logic br, input logic jal, input logic jalr, input logic tk,
                       input logic [31:0] pc, input logic [31:0] imm, input logic [31:0] rs1);
    bus.ex_valid     = 1'b1;
    bus.ex_is_branch = br;
    bus.ex_is_jal    = jal;
    bus.ex_is_jalr   = jalr;
    bus.branch_taken = tk;
    bus.ex_pc        = pc;
    bus.ex_imm       = imm;
    bus.ex_rs1       = rs1;
    tick();
    idle_inputs();
  endtask

  // Complete an outstanding redirect and wait (bounded) for the block to return to IDLE.
  task automatic release_redirect(input string name);
    bus.redir_ready = 1'b1;
    tick();
    bus.redir_ready = 1'b0;
    for (int k = 0; k < 10 && !bus.ex_ready; k++) tick();
    n_tests++;
    if (bus.ex_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_return_idle: ex_ready got %b want 1 within 10 cycles", name, bus.ex_ready);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    idle_inputs();
    bus.redir_ready = 1'b0;
    repeat (2) tick();
    n_tests++;
    if ({bus.redir_valid, bus.flush, bus.exc_misaligned, bus.ex_ready} !== 4'b0001) begin
      n_fail++;
      $display("FAIL reset_ctrl: {rv,flush,exc,ready} got %b want 0001",
               {bus.redir_valid, bus.flush, bus.exc_misaligned, bus.ex_ready});
    end
    n_tests++;
    if (bus.redir_pc !== 32'h0 || bus.exc_pc !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_pcs: redir_pc %h exc_pc %h want 0", bus.redir_pc, bus.exc_pc);
    end
    n_tests++;
    if (bus.stat_branches !== '0 || bus.stat_taken !== '0) begin
      n_fail++;
      $display("FAIL reset_stats: got %0d/%0d want 0/0", bus.stat_branches, bus.stat_taken);
    end
    reset = 1'b0;
    tick();
  endtask

  // BEQ taken, then fetch stalls 3 cycles before accepting; 2 drain cycles follow.
  task automatic test_beq_taken_stall;
    n_tests++;
    if (bus.ex_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL beq_ready_before: got %b want 1", bus.ex_ready);
    end
    issue(1'b1, 1'b0, 1'b0, 1'b1, 32'h100, 32'h20, 32'h0);
    n_tests++;
    if ({bus.redir_valid, bus.flush, bus.ex_ready} !== 3'b110 || bus.redir_pc !== 32'h120) begin
      n_fail++;
      $display("FAIL beq_redirect: {rv,flush,ready} %b pc %h want 110 pc 00000120",
               {bus.redir_valid, bus.flush, bus.ex_ready}, bus.redir_pc);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if (bus.redir_valid !== 1'b1 || bus.redir_pc !== 32'h120 || bus.flush !== 1'b1) begin
        n_fail++;
        $display("FAIL stall_hold_%0d: rv %b pc %h flush %b want 1 00000120 1",
                 i, bus.redir_valid, bus.redir_pc, bus.flush);
      end
    end
    bus.redir_ready = 1'b1;
    tick();
    bus.redir_ready = 1'b0;
    n_tests++;
    if ({bus.redir_valid, bus.flush, bus.ex_ready} !== 3'b010) begin
      n_fail++;
      $display("FAIL drain1: {rv,flush,ready} got %b want 010", {bus.redir_valid, bus.flush, bus.ex_ready});
    end
    tick();
    n_tests++;
    if ({bus.redir_valid, bus.flush, bus.ex_ready} !== 3'b010) begin
      n_fail++;
      $display("FAIL drain2: {rv,flush,ready} got %b want 010", {bus.redir_valid, bus.flush, bus.ex_ready});
    end
    tick();
    n_tests++;
    if ({bus.redir_valid, bus.flush, bus.ex_ready} !== 3'b001) begin
      n_fail++;
      $display("FAIL drain_exit: {rv,flush,ready} got %b want 001", {bus.redir_valid, bus.flush, bus.ex_ready});
    end
  endtask

  // BNE not taken stays in IDLE; stray redir_ready is ignored; next instruction accepted at once.
  task automatic test_not_taken;
    issue(1'b1, 1'b0, 1'b0, 1'b0, 32'h200, 32'h40, 32'h0);
    n_tests++;
    if ({bus.redir_valid, bus.flush, bus.ex_ready} !== 3'b001) begin
      n_fail++;
      $display("FAIL bne_nt: {rv,flush,ready} got %b want 001", {bus.redir_valid, bus.flush, bus.ex_ready});
    end
    bus.redir_ready = 1'b1;
    tick();
    bus.redir_ready = 1'b0;
    n_tests++;
    if ({bus.redir_valid, bus.flush, bus.ex_ready} !== 3'b001) begin
      n_fail++;
      $display("FAIL stray_ready: {rv,flush,ready} got %b want 001", {bus.redir_valid, bus.flush, bus.ex_ready});
    end
    issue(1'b0, 1'b1, 1'b0, 1'b0, 32'h204, 32'h10, 32'h0);
    n_tests++;
    if (bus.redir_valid !== 1'b1 || bus.redir_pc !== 32'h214) begin
      n_fail++;
      $display("FAIL after_nt_jal: rv %b pc %h want 1 00000214", bus.redir_valid, bus.redir_pc);
    end
    release_redirect("after_nt_jal");
    // back-to-back: accepted on the first IDLE cycle, address wraps mod 2^32
    issue(1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFF0, 32'h20, 32'h0);
    n_tests++;
    if (bus.redir_valid !== 1'b1 || bus.redir_pc !== 32'h10) begin
      n_fail++;
      $display("FAIL jal_wrap: rv %b pc %h want 1 00000010", bus.redir_valid, bus.redir_pc);
    end
    release_redirect("jal_wrap");
  endtask

  task automatic test_jalr;
    // 0x1005 + 0 -> bit 0 cleared -> 0x1004 (aligned)
    issue(1'b0, 1'b0, 1'b1, 1'b0, 32'h500, 32'h0, 32'h1005);
    n_tests++;
    if (bus.redir_valid !== 1'b1 || bus.redir_pc !== 32'h1004) begin
      n_fail++;
      $display("FAIL jalr_clear0: rv %b pc %h want 1 00001004", bus.redir_valid, bus.redir_pc);
    end
    release_redirect("jalr_clear0");
    // 0x1001 + 3 = 0x1004
    issue(1'b0, 1'b0, 1'b1, 1'b0, 32'h504, 32'h3, 32'h1001);
    n_tests++;
    if (bus.redir_valid !== 1'b1 || bus.redir_pc !== 32'h1004) begin
      n_fail++;
      $display("FAIL jalr_sum: rv %b pc %h want 1 00001004", bus.redir_valid, bus.redir_pc);
    end
    release_redirect("jalr_sum");
    // 0x1003 -> 0x1002 has bit 1 set: misaligned, no redirect
    issue(1'b0, 1'b0, 1'b1, 1'b0, 32'h508, 32'h0, 32'h1003);
    n_tests++;
    if ({bus.exc_misaligned, bus.redir_valid, bus.flush} !== 3'b100 || bus.exc_pc !== 32'h508) begin
      n_fail++;
      $display("FAIL jalr_1002_a: {exc,rv,flush} %b exc_pc %h want 100 00000508",
               {bus.exc_misaligned, bus.redir_valid, bus.flush}, bus.exc_pc);
    end
    // 0x1001 + 1 -> 0x1002, also misaligned
    issue(1'b0, 1'b0, 1'b1, 1'b0, 32'h50C, 32'h1, 32'h1001);
    n_tests++;
    if ({bus.exc_misaligned, bus.redir_valid, bus.flush} !== 3'b100 || bus.exc_pc !== 32'h50C) begin
      n_fail++;
      $display("FAIL jalr_1002_b: {exc,rv,flush} %b exc_pc %h want 100 0000050c",
               {bus.exc_misaligned, bus.redir_valid, bus.flush}, bus.exc_pc);
    end
    tick();
  endtask

  task automatic test_misaligned;
    issue(1'b0, 1'b1, 1'b0, 1'b0, 32'h300, 32'h6, 32'h0);
    n_tests++;
    if ({bus.exc_misaligned, bus.redir_valid, bus.flush, bus.ex_ready} !== 4'b1001 ||
        bus.exc_pc !== 32'h300) begin
      n_fail++;
      $display("FAIL jal_misaligned: {exc,rv,flush,ready} %b exc_pc %h want 1001 00000300",
               {bus.exc_misaligned, bus.redir_valid, bus.flush, bus.ex_ready}, bus.exc_pc);
    end
    tick();
    n_tests++;
    if (bus.exc_misaligned !== 1'b0 || bus.redir_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL exc_one_cycle: exc %b rv %b want 0 0", bus.exc_misaligned, bus.redir_valid);
    end
  endtask

  task automatic test_reset_mid_req;
    issue(1'b1, 1'b0, 1'b0, 1'b1, 32'h600, 32'h100, 32'h0);
    n_tests++;
    if (bus.redir_valid !== 1'b1 || bus.redir_pc !== 32'h700) begin
      n_fail++;
      $display("FAIL pre_reset_req: rv %b pc %h want 1 00000700", bus.redir_valid, bus.redir_pc);
    end
    reset = 1'b1;
    #1;
    n_tests++;
    if ({bus.redir_valid, bus.flush, bus.ex_ready} !== 3'b001 || bus.redir_pc !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_mid_req: {rv,flush,ready} %b pc %h want 001 00000000",
               {bus.redir_valid, bus.flush, bus.ex_ready}, bus.redir_pc);
    end
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_stats;
`ifdef BRANCH_STATS_EN
    issue(1'b1, 1'b0, 1'b0, 1'b1, 32'h800, 32'h8, 32'h0);
    release_redirect("stat_b1");
    issue(1'b1, 1'b0, 1'b0, 1'b1, 32'h808, 32'h10, 32'h0);
    release_redirect("stat_b2");
    issue(1'b1, 1'b0, 1'b0, 1'b0, 32'h818, 32'h40, 32'h0);
    issue(1'b0, 1'b1, 1'b0, 1'b0, 32'h81C, 32'h4, 32'h0);
    release_redirect("stat_jal");
    issue(1'b1, 1'b0, 1'b0, 1'b1, 32'h820, 32'h20, 32'h0);
    release_redirect("stat_b4");
    n_tests++;
    if (bus.stat_branches !== 32'd4 || bus.stat_taken !== 32'd3) begin
      n_fail++;
      $display("FAIL stats_count: got %0d/%0d want 4/3", bus.stat_branches, bus.stat_taken);
    end
    reset = 1'b1;
    #1;
    n_tests++;
    if (bus.stat_branches !== 32'd0 || bus.stat_taken !== 32'd0) begin
      n_fail++;
      $display("FAIL stats_reset: got %0d/%0d want 0/0", bus.stat_branches, bus.stat_taken);
    end
    tick();
    reset = 1'b0;
    tick();
`else
    issue(1'b1, 1'b0, 1'b0, 1'b0, 32'h800, 32'h8, 32'h0);
    n_tests++;
    if (bus.stat_branches !== 32'd0 || bus.stat_taken !== 32'd0) begin
      n_fail++;
      $display("FAIL stats_tied: got %0d/%0d want 0/0", bus.stat_branches, bus.stat_taken);
    end
`endif
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_beq_taken_stall();
    test_not_taken();
    test_jalr();
    test_misaligned();
    test_reset_mid_req();
    test_stats();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
